// File: rtl/exec_units.sv
// exec_units: ALU plus two-stage load/store unit sharing one registered
// result bus toward the ROB.
//
// Ports
//   in_clk, in_rst (async, active-low)
//   ALU issue : in_rs_alu_start, in_rs_alu_fu_op, in_rs_alu_val_a/b,
//               in_rs_alu_dst_rob_index, in_rs_alu_set_nzcv, in_rs_alu_nzcv,
//               in_rob_alu_cond_codes
//   LS issue  : in_rs_ls_start, in_rs_ls_fu_op (0 LDUR, 1 STUR),
//               in_rs_ls_val_a/b, in_rs_ls_dst_rob_index
//   Ready     : out_rs_alu_ready, out_rs_ls_ready
//   Result    : out_rob_done, out_rob_dst_rob_index, out_rob_value,
//               out_rob_set_nzcv, out_rob_nzcv, out_alu_condition
module exec_units #(
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 4,
  parameter int DMEM_WORDS   = 256
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rs_alu_start,
  input  logic [3:0]              in_rs_alu_fu_op,
  input  logic [GPR_SIZE-1:0]     in_rs_alu_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_alu_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_alu_dst_rob_index,
  input  logic                    in_rs_alu_set_nzcv,
  input  logic [3:0]              in_rs_alu_nzcv,
  input  logic [3:0]              in_rob_alu_cond_codes,
  input  logic                    in_rs_ls_start,
  input  logic [3:0]              in_rs_ls_fu_op,
  input  logic [GPR_SIZE-1:0]     in_rs_ls_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_ls_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_ls_dst_rob_index,
  output logic                    out_rs_alu_ready,
  output logic                    out_rs_ls_ready,
  output logic                    out_rob_done,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic                    out_rob_set_nzcv,
  output logic [3:0]              out_rob_nzcv,
  output logic                    out_alu_condition
);

  localparam int IDX_W = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam int MSB   = GPR_SIZE - 1;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_ASR,
    OP_MOV, OP_CSEL, OP_CSINC, OP_CSINV, OP_CSNEG, OP_BCOND
  } alu_op_e;

  // State
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_store_q, s1_store_d;
  logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
  logic [GPR_SIZE-1:0]     s1_data_q, s1_data_d;
  logic [ROB_IDX_SIZE-1:0] s1_tag_q, s1_tag_d;
  logic                    done_q, done_d;
  logic [ROB_IDX_SIZE-1:0] tag_q, tag_d;
  logic [GPR_SIZE-1:0]     value_q, value_d;
  logic                    set_q, set_d;
  logic [3:0]              nzcv_q, nzcv_d;
  logic                    cond_q, cond_d;
  logic [GPR_SIZE-1:0]     mem_q [DMEM_WORDS];

  // Both units stall while a load/store sits in stage1: its result owns the
  // bus next edge, so an ALU op accepted now would collide with it.
  logic alu_fire, ls_fire;
  assign out_rs_ls_ready  = in_rst & ~s1_valid_q;
  assign out_rs_alu_ready = in_rst & ~s1_valid_q;
  assign alu_fire = in_rs_alu_start & out_rs_alu_ready;
  assign ls_fire  = in_rs_ls_start & out_rs_ls_ready;

  // ARM condition: even codes test a base predicate, odd codes invert it,
  // except that 14 (AL) and 15 (NV) are both always true.
  logic cond_base, cond_true;
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    cond_base = 1'b1;
    case (in_rob_alu_cond_codes[3:1])
      3'd0:    cond_base = in_rs_alu_nzcv[2];
      3'd1:    cond_base = in_rs_alu_nzcv[1];
      3'd2:    cond_base = in_rs_alu_nzcv[3];
      3'd3:    cond_base = in_rs_alu_nzcv[0];
      3'd4:    cond_base = in_rs_alu_nzcv[1] & ~in_rs_alu_nzcv[2];
      3'd5:    cond_base = (in_rs_alu_nzcv[3] == in_rs_alu_nzcv[0]);
      3'd6:    cond_base = ~in_rs_alu_nzcv[2] & (in_rs_alu_nzcv[3] == in_rs_alu_nzcv[0]);
      default: cond_base = 1'b1;
    endcase
    cond_true = (in_rob_alu_cond_codes[0] && (in_rob_alu_cond_codes[3:1] != 3'b111))
              ? ~cond_base : cond_base;
  end

  // ALU datapath
  alu_op_e             alu_op;
  logic [5:0]          shamt;
  logic [GPR_SIZE:0]   sum_ext;
  logic [GPR_SIZE-1:0] alu_value;
  logic                alu_arith, alu_ovf, alu_is_cond;
  logic [3:0]          alu_nzcv;
  assign alu_op = alu_op_e'(in_rs_alu_fu_op);
  assign shamt  = in_rs_alu_val_b[5:0];

  always_comb begin
    sum_ext     = '0;
    alu_value   = '0;
    alu_arith   = 1'b0;
    alu_ovf     = 1'b0;
    alu_is_cond = 1'b0;
    case (alu_op)
      OP_ADD: begin
        sum_ext   = {1'b0, in_rs_alu_val_a} + {1'b0, in_rs_alu_val_b};
        alu_value = sum_ext[MSB:0];
        alu_arith = 1'b1;
        alu_ovf   = (in_rs_alu_val_a[MSB] == in_rs_alu_val_b[MSB]) &&
                    (alu_value[MSB] != in_rs_alu_val_a[MSB]);
      end
      OP_SUB: begin
        // a + ~b + 1: carry-out set means no borrow.
        sum_ext   = {1'b0, in_rs_alu_val_a} + {1'b0, ~in_rs_alu_val_b} + (GPR_SIZE+1)'(1);
        alu_value = sum_ext[MSB:0];
        alu_arith = 1'b1;
        alu_ovf   = (in_rs_alu_val_a[MSB] != in_rs_alu_val_b[MSB]) &&
                    (alu_value[MSB] != in_rs_alu_val_a[MSB]);
      end
      OP_AND:   alu_value = in_rs_alu_val_a & in_rs_alu_val_b;
      OP_ORR:   alu_value = in_rs_alu_val_a | in_rs_alu_val_b;
      OP_EOR:   alu_value = in_rs_alu_val_a ^ in_rs_alu_val_b;
      OP_LSL:   alu_value = in_rs_alu_val_a << shamt;
      OP_LSR:   alu_value = in_rs_alu_val_a >> shamt;
      OP_ASR:   alu_value = $signed(in_rs_alu_val_a) >>> shamt;
      OP_MOV:   alu_value = in_rs_alu_val_b;
      OP_CSEL: begin
        alu_is_cond = 1'b1;
        alu_value   = cond_true ? in_rs_alu_val_a : in_rs_alu_val_b;
      end
      OP_CSINC: begin
        alu_is_cond = 1'b1;
        alu_value   = cond_true ? in_rs_alu_val_a : in_rs_alu_val_b + GPR_SIZE'(1);
      end
      OP_CSINV: begin
        alu_is_cond = 1'b1;
        alu_value   = cond_true ? in_rs_alu_val_a : ~in_rs_alu_val_b;
      end
      OP_CSNEG: begin
        alu_is_cond = 1'b1;
        alu_value   = cond_true ? in_rs_alu_val_a : -in_rs_alu_val_b;
      end
      OP_BCOND: alu_is_cond = 1'b1;
      default:  alu_value = '0;
    endcase
    // Non-arithmetic ops report N/Z from the result and clear C/V.
    if (in_rs_alu_set_nzcv)
      alu_nzcv = {alu_value[MSB], (alu_value == '0),
                  alu_arith & sum_ext[GPR_SIZE], alu_arith & alu_ovf};
    else
      alu_nzcv = in_rs_alu_nzcv;
  end

  // LS stage1: stores use val_a alone as the address; val_b is the data.
  logic                ls_is_store;
  logic [GPR_SIZE-1:0] ls_addr;
  logic [7:0]          ls_word;
  logic                unused_addr_bits;
  assign ls_is_store = (in_rs_ls_fu_op == 4'd1);
  assign ls_addr = in_rs_ls_val_a + (ls_is_store ? {GPR_SIZE{1'b0}} : in_rs_ls_val_b);
  assign ls_word = ls_addr[10:3];
  assign unused_addr_bits = ^{ls_addr[GPR_SIZE-1:11], ls_addr[2:0]};

  always_comb begin
    s1_valid_d = ls_fire;
    s1_store_d = s1_store_q;
    s1_idx_d   = s1_idx_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    if (ls_fire) begin
      s1_store_d = ls_is_store;
      s1_idx_d   = IDX_W'(32'(ls_word) % DMEM_WORDS);
      s1_data_d  = in_rs_ls_val_b;
      s1_tag_d   = in_rs_ls_dst_rob_index;
    end
  end

  // Result bus: an accepted ALU op and a stage1 LS op are mutually
  // exclusive because the ALU is not ready while stage1 is occupied.
  always_comb begin
    done_d = 1'b0;
    tag_d  = tag_q;
    value_d = value_q;
    set_d  = set_q;
    nzcv_d = nzcv_q;
    cond_d = cond_q;
    if (alu_fire) begin
      done_d  = 1'b1;
      tag_d   = in_rs_alu_dst_rob_index;
      value_d = alu_value;
      set_d   = in_rs_alu_set_nzcv;
      nzcv_d  = alu_nzcv;
      cond_d  = alu_is_cond & cond_true;
    end else if (s1_valid_q) begin
      done_d  = 1'b1;
      tag_d   = s1_tag_q;
      value_d = s1_store_q ? '0 : mem_q[s1_idx_q];
      set_d   = 1'b0;
      nzcv_d  = 4'b0000;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      s1_valid_q <= 1'b0;
      s1_store_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      done_q     <= 1'b0;
      tag_q      <= '0;
      value_q    <= '0;
      set_q      <= 1'b0;
      nzcv_q     <= 4'b0000;
      cond_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      s1_valid_q <= s1_valid_d;
      s1_store_q <= s1_store_d;
      s1_idx_q   <= s1_idx_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      done_q     <= done_d;
      tag_q      <= tag_d;
      value_q    <= value_d;
      set_q      <= set_d;
      nzcv_q     <= nzcv_d;
      cond_q     <= cond_d;
    end
  end

  // NOTE: the data memory must read as zero after reset, so it is built from
  // resettable flops rather than an inferred RAM macro (which cannot clear).
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) mem_q[i] <= '0;
    end else if (s1_valid_q && s1_store_q) begin
      mem_q[s1_idx_q] <= s1_data_q;
    end
  end

  assign out_rob_done          = done_q;
  assign out_rob_dst_rob_index = tag_q;
  assign out_rob_value         = value_q;
  assign out_rob_set_nzcv      = set_q;
  assign out_rob_nzcv          = nzcv_q;
  assign out_alu_condition     = cond_q;

endmodule

// File: tb/tb_exec_units.sv
// Self-checking bench for exec_units: fixed vector table, directed
// load/store and reset sequences, then randomized traffic against a
// behavioural reference model.
module tb_exec_units;

  logic        in_clk, in_rst;
  logic        in_rs_alu_start, in_rs_alu_set_nzcv;
  logic [3:0]  in_rs_alu_fu_op, in_rs_alu_nzcv, in_rob_alu_cond_codes;
  logic [63:0] in_rs_alu_val_a, in_rs_alu_val_b;
  logic [3:0]  in_rs_alu_dst_rob_index;
  logic        in_rs_ls_start;
  logic [3:0]  in_rs_ls_fu_op;
  logic [63:0] in_rs_ls_val_a, in_rs_ls_val_b;
  logic [3:0]  in_rs_ls_dst_rob_index;
  logic        out_rs_alu_ready, out_rs_ls_ready, out_rob_done;
  logic [3:0]  out_rob_dst_rob_index, out_rob_nzcv;
  logic [63:0] out_rob_value;
  logic        out_rob_set_nzcv, out_alu_condition;

  exec_units dut (
    .in_clk(in_clk), .in_rst(in_rst),
    .in_rs_alu_start(in_rs_alu_start), .in_rs_alu_fu_op(in_rs_alu_fu_op),
    .in_rs_alu_val_a(in_rs_alu_val_a), .in_rs_alu_val_b(in_rs_alu_val_b),
    .in_rs_alu_dst_rob_index(in_rs_alu_dst_rob_index),
    .in_rs_alu_set_nzcv(in_rs_alu_set_nzcv), .in_rs_alu_nzcv(in_rs_alu_nzcv),
    .in_rob_alu_cond_codes(in_rob_alu_cond_codes),
    .in_rs_ls_start(in_rs_ls_start), .in_rs_ls_fu_op(in_rs_ls_fu_op),
    .in_rs_ls_val_a(in_rs_ls_val_a), .in_rs_ls_val_b(in_rs_ls_val_b),
    .in_rs_ls_dst_rob_index(in_rs_ls_dst_rob_index),
    .out_rs_alu_ready(out_rs_alu_ready), .out_rs_ls_ready(out_rs_ls_ready),
    .out_rob_done(out_rob_done), .out_rob_dst_rob_index(out_rob_dst_rob_index),
    .out_rob_value(out_rob_value), .out_rob_set_nzcv(out_rob_set_nzcv),
    .out_rob_nzcv(out_rob_nzcv), .out_alu_condition(out_alu_condition)
  );

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [63:0] value;
    logic [3:0]  nzcv;
    logic        set;
    logic        cond;
  } alu_res_t;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b;
    logic        set;
    logic [3:0]  nzcv, cc;
    logic [63:0] exp_value;
    logic [3:0]  exp_nzcv;
    logic        exp_cond;
  } alu_vec_t;

  logic [63:0] mem_m [256];

  // Reference ALU: condition table spelled out per code, carries and
  // overflow from unsigned/signed comparisons.
  function automatic alu_res_t alu_ref(input logic [3:0] op, input logic [63:0] a, b,
                                       input logic set, input logic [3:0] flags,
                                       input logic [3:0] cc);
    alu_res_t res;
    logic fn, fz, fc, fv, taken, carry, ovf, arith, conditional;
    logic [63:0] r;
    fn = flags[3]; fz = flags[2]; fc = flags[1]; fv = flags[0];
    case (cc)
      4'd0:  taken = fz;
      4'd1:  taken = !fz;
      4'd2:  taken = fc;
      4'd3:  taken = !fc;
      4'd4:  taken = fn;
      4'd5:  taken = !fn;
      4'd6:  taken = fv;
      4'd7:  taken = !fv;
      4'd8:  taken = fc && !fz;
      4'd9:  taken = !fc || fz;
      4'd10: taken = (fn == fv);
      4'd11: taken = (fn != fv);
      4'd12: taken = !fz && (fn == fv);
      4'd13: taken = fz || (fn != fv);
      default: taken = 1'b1;
    endcase
    carry = 0; ovf = 0; arith = 0; conditional = 0; r = 0;
    case (op)
      4'd0: begin
        r = a + b; arith = 1; carry = (r < a);
        ovf = (($signed(a) < 0) == ($signed(b) < 0)) && (($signed(r) < 0) != ($signed(a) < 0));
      end
      4'd1: begin
        r = a - b; arith = 1; carry = (a >= b);
        ovf = (($signed(a) < 0) != ($signed(b) < 0)) && (($signed(r) < 0) != ($signed(a) < 0));
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = a << b[5:0];
      4'd6:  r = a >> b[5:0];
      4'd7:  r = $signed(a) >>> b[5:0];
      4'd8:  r = b;
      4'd9:  begin conditional = 1; r = taken ? a : b; end
      4'd10: begin conditional = 1; r = taken ? a : b + 64'd1; end
      4'd11: begin conditional = 1; r = taken ? a : ~b; end
      4'd12: begin conditional = 1; r = taken ? a : 64'd0 - b; end
      4'd13: begin conditional = 1; r = 0; end
      default: r = 0;
    endcase
    res.value = r;
    res.set   = set;
    res.cond  = conditional && taken;
    res.nzcv  = set ? {r[63], r == 64'd0, arith && carry, arith && ovf} : flags;
    return res;
  endfunction

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [63:0] a, b, input logic [3:0] tag,
                           input logic set, input logic [3:0] flags, input logic [3:0] cc);
    in_rs_alu_start = 1'b1; in_rs_alu_fu_op = op;
    in_rs_alu_val_a = a; in_rs_alu_val_b = b; in_rs_alu_dst_rob_index = tag;
    in_rs_alu_set_nzcv = set; in_rs_alu_nzcv = flags; in_rob_alu_cond_codes = cc;
  endtask

  task automatic drive_ls(input logic [3:0] op, input logic [63:0] a, b, input logic [3:0] tag);
    in_rs_ls_start = 1'b1; in_rs_ls_fu_op = op;
    in_rs_ls_val_a = a; in_rs_ls_val_b = b; in_rs_ls_dst_rob_index = tag;
  endtask

  task automatic idle();
    in_rs_alu_start = 1'b0;
    in_rs_ls_start  = 1'b0;
  endtask

  task automatic check_alu_bus(input string name, input alu_res_t e, input logic [3:0] tag);
    check({name, ".done"},  out_rob_done, 1);
    check({name, ".tag"},   out_rob_dst_rob_index, tag);
    check({name, ".value"}, out_rob_value, e.value);
    check({name, ".nzcv"},  out_rob_nzcv, e.nzcv);
    check({name, ".set"},   out_rob_set_nzcv, e.set);
    check({name, ".cond"},  out_alu_condition, e.cond);
  endtask

  task automatic check_ls_bus(input string name, input logic [63:0] value, input logic [3:0] tag);
    check({name, ".done"},  out_rob_done, 1);
    check({name, ".tag"},   out_rob_dst_rob_index, tag);
    check({name, ".value"}, out_rob_value, value);
    check({name, ".set"},   out_rob_set_nzcv, 0);
    check({name, ".nzcv"},  out_rob_nzcv, 0);
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 100));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  alu_vec_t vecs [16];

  initial begin
    alu_res_t    e;
    logic [63:0] addr, exp_v;
    logic [3:0]  op, tag, ltag, flags, cc;
    logic [63:0] a, b, la, lb;
    logic        set;
    int          idx;

    vecs[0]  = '{4'd0,  64'd5, 64'd7, 1'b1, 4'b0000, 4'd14, 64'd12, 4'b0000, 1'b0};
    vecs[1]  = '{4'd1,  64'd3, 64'd3, 1'b1, 4'b0000, 4'd14, 64'd0, 4'b0110, 1'b0};
    vecs[2]  = '{4'd1,  64'd0, 64'd1, 1'b1, 4'b0000, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0};
    vecs[3]  = '{4'd9,  64'd1, 64'd2, 1'b0, 4'b0100, 4'd0,  64'd1, 4'b0100, 1'b1};
    vecs[4]  = '{4'd9,  64'd1, 64'd2, 1'b0, 4'b0000, 4'd0,  64'd2, 4'b0000, 1'b0};
    vecs[5]  = '{4'd0,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'b0000, 4'd14,
                 64'h8000_0000_0000_0000, 4'b1001, 1'b0};
    vecs[6]  = '{4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 4'b0000, 4'd14, 64'd0, 4'b0110, 1'b0};
    vecs[7]  = '{4'd7,  64'h8000_0000_0000_0000, 64'h104, 1'b1, 4'b0000, 4'd14,
                 64'hF800_0000_0000_0000, 4'b1000, 1'b0};
    vecs[8]  = '{4'd5,  64'd1, 64'd63, 1'b0, 4'b1010, 4'd14, 64'h8000_0000_0000_0000, 4'b1010, 1'b0};
    vecs[9]  = '{4'd12, 64'd9, 64'd5, 1'b0, 4'b0100, 4'd1,  64'hFFFF_FFFF_FFFF_FFFB, 4'b0100, 1'b0};
    vecs[10] = '{4'd10, 64'd9, 64'd5, 1'b0, 4'b1001, 4'd10, 64'd9, 4'b1001, 1'b1};
    vecs[11] = '{4'd13, 64'd1, 64'd2, 1'b0, 4'b0000, 4'd15, 64'd0, 4'b0000, 1'b1};
    vecs[12] = '{4'd2,  64'hFF00, 64'h0F0F, 1'b1, 4'b1111, 4'd14, 64'h0F00, 4'b0000, 1'b0};
    vecs[13] = '{4'd8,  64'd7, 64'd0, 1'b1, 4'b0011, 4'd14, 64'd0, 4'b0100, 1'b0};
    vecs[14] = '{4'd11, 64'd3, 64'd0, 1'b0, 4'b0010, 4'd8,  64'd3, 4'b0010, 1'b1};
    vecs[15] = '{4'd4,  64'hF0, 64'hFF, 1'b0, 4'b0101, 4'd14, 64'h0F, 4'b0101, 1'b0};

    for (int i = 0; i < 256; i++) mem_m[i] = 64'd0;

    // Reset state
    in_rst = 1'b0;
    idle();
    drive_alu(4'd0, 64'd0, 64'd0, 4'd0, 1'b0, 4'd0, 4'd0);
    drive_ls(4'd0, 64'd0, 64'd0, 4'd0);
    idle();
    #2;
    check("rst.done", out_rob_done, 0);
    check("rst.value", out_rob_value, 0);
    check("rst.tag", out_rob_dst_rob_index, 0);
    check("rst.nzcv", out_rob_nzcv, 0);
    check("rst.set", out_rob_set_nzcv, 0);
    check("rst.cond", out_alu_condition, 0);
    check("rst.alu_ready", out_rs_alu_ready, 0);
    check("rst.ls_ready", out_rs_ls_ready, 0);
    tick(); tick();
    in_rst = 1'b1;
    #1;
    check("rel.alu_ready", out_rs_alu_ready, 1);
    check("rel.ls_ready", out_rs_ls_ready, 1);

    // Table vectors issued back to back, one result per cycle
    for (int i = 0; i < 16; i++) begin
      drive_alu(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), vecs[i].set, vecs[i].nzcv, vecs[i].cc);
      tick();
      e.value = vecs[i].exp_value;
      e.nzcv  = vecs[i].exp_nzcv;
      e.set   = vecs[i].set;
      e.cond  = vecs[i].exp_cond;
      check_alu_bus($sformatf("vec%0d", i), e, 4'(i));
    end
    idle();
    tick();
    check("idle.done", out_rob_done, 0);
    check("idle.value_hold", out_rob_value, vecs[15].exp_value);

    // Store then load through the two-stage pipeline
    drive_ls(4'd1, 64'h40, 64'hABCD, 4'd2);
    tick();
    idle();
    check("stur.s1_done", out_rob_done, 0);
    check("stur.s1_alu_ready", out_rs_alu_ready, 0);
    check("stur.s1_ls_ready", out_rs_ls_ready, 0);
    tick();
    check_ls_bus("stur", 64'd0, 4'd2);
    mem_m[8] = 64'hABCD;
    drive_ls(4'd0, 64'h38, 64'd8, 4'd5);
    tick();
    idle();
    check("ldur.s1_done", out_rob_done, 0);
    tick();
    check_ls_bus("ldur", 64'hABCD, 4'd5);

    // Simultaneous ALU + LS, with a blocked ALU start during N+1
    drive_alu(4'd0, 64'd10, 64'd20, 4'd1, 1'b1, 4'd0, 4'd14);
    drive_ls(4'd0, 64'h30, 64'h10, 4'd6);
    tick();
    e = '{64'd30, 4'b0000, 1'b1, 1'b0};
    check_alu_bus("sim.alu", e, 4'd1);
    check("sim.alu_ready", out_rs_alu_ready, 0);
    check("sim.ls_ready", out_rs_ls_ready, 0);
    in_rs_ls_start = 1'b0;
    drive_alu(4'd1, 64'd1, 64'd1, 4'd9, 1'b1, 4'd0, 4'd14);
    tick();
    idle();
    check_ls_bus("sim.ls", 64'hABCD, 4'd6);
    tick();
    check("sim.blocked_done", out_rob_done, 0);

    // Reset between LDUR issue and completion
    drive_ls(4'd0, 64'h40, 64'd0, 4'd7);
    tick();
    idle();
    #2 in_rst = 1'b0;
    #1;
    check("midrst.done", out_rob_done, 0);
    check("midrst.value", out_rob_value, 0);
    check("midrst.tag", out_rob_dst_rob_index, 0);
    check("midrst.alu_ready", out_rs_alu_ready, 0);
    check("midrst.ls_ready", out_rs_ls_ready, 0);
    #2 in_rst = 1'b1;
    #1;
    check("midrst.rel_alu_ready", out_rs_alu_ready, 1);
    check("midrst.rel_ls_ready", out_rs_ls_ready, 1);
    tick();
    check("midrst.no_done", out_rob_done, 0);
    for (int i = 0; i < 256; i++) mem_m[i] = 64'd0;
    drive_ls(4'd0, 64'h40, 64'd0, 4'd3);
    tick();
    idle();
    tick();
    check_ls_bus("memclr", 64'd0, 4'd3);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int kind;
      kind = $urandom_range(0, 3);
      op = 4'($urandom_range(0, 13));
      a = rand64(); b = rand64();
      set = (op <= 4'd8) ? 1'($urandom_range(0, 1)) : 1'b0;
      flags = 4'($urandom); cc = 4'($urandom); tag = 4'($urandom);
      la = 64'($urandom_range(0, 4095));
      ltag = 4'($urandom);
      if (kind != 2) drive_alu(op, a, b, tag, set, flags, cc);
      if (kind >= 2) begin
        if ($urandom_range(0, 1) == 1) begin
          lb = {$urandom, $urandom};
          drive_ls(4'd1, la, lb, ltag);
          addr = la;
          idx = int'(addr[10:3]);
          exp_v = 64'd0;
          mem_m[idx] = lb;
        end else begin
          lb = 64'($urandom_range(0, 2047));
          drive_ls(4'd0, la, lb, ltag);
          addr = la + lb;
          idx = int'(addr[10:3]);
          exp_v = mem_m[idx];
        end
      end
      tick();
      idle();
      if (kind != 2) check_alu_bus($sformatf("rnd%0d.alu", it), alu_ref(op, a, b, set, flags, cc), tag);
      else check($sformatf("rnd%0d.s1_done", it), out_rob_done, 0);
      if (kind >= 2) begin
        check($sformatf("rnd%0d.s1_ready", it), out_rs_ls_ready, 0);
        tick();
        check_ls_bus($sformatf("rnd%0d.ls", it), exp_v, ltag);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exec_units.md
EXEC_UNITS -- requirements
Module: exec_units

Interface
REQ-001 Parameters (name, default, meaning): GPR_SIZE, 64, operand/result width; ROB_IDX_SIZE, 4, ROB tag width; DMEM_WORDS, 256, 64-bit data-memory words.
REQ-002 Port in_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port in_rst, input, 1, asynchronous active-low reset; 0 resets all state immediately, regardless of clock.
REQ-004 Port in_rs_alu_start, input, 1, ALU issue strobe.
REQ-005 Port in_rs_alu_fu_op, input, 4, ALU op: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 LSL, 6 LSR, 7 ASR, 8 MOV, 9 CSEL, 10 CSINC, 11 CSINV, 12 CSNEG, 13 BCOND; 14-15 reserved.
REQ-006 Ports in_rs_alu_val_a / in_rs_alu_val_b, input, GPR_SIZE, ALU operands.
REQ-007 Port in_rs_alu_dst_rob_index, input, ROB_IDX_SIZE, ALU result tag.
REQ-008 Port in_rs_alu_set_nzcv, input, 1, op writes flags.
REQ-009 Port in_rs_alu_nzcv, input, 4, current flags {N,Z,C,V}, MSB first.
REQ-010 Port in_rob_alu_cond_codes, input, 4, ARM condition: 0 EQ .. 13 LE, 14 AL, 15 NV.
REQ-011 Ports in_rs_ls_start (1), in_rs_ls_fu_op (4: 0 LDUR, 1 STUR), in_rs_ls_val_a / in_rs_ls_val_b (GPR_SIZE), in_rs_ls_dst_rob_index (ROB_IDX_SIZE), all input, load/store issue.
REQ-012 Ports out_rs_alu_ready and out_rs_ls_ready, output, 1 each, unit accepts a start this cycle.
REQ-013 Ports out_rob_done (1), out_rob_dst_rob_index (ROB_IDX_SIZE), out_rob_value (GPR_SIZE), out_rob_set_nzcv (1), out_rob_nzcv (4), all output, single shared registered result bus.
REQ-014 Port out_alu_condition, output, 1, registered condition result of the last ALU op.

Function
REQ-015 Start is accepted only when the matching ready is 1 at the rising edge; a start with ready 0 is ignored.
REQ-016 ALU latency is 1: an op accepted at edge N drives out_rob_done=1 with its tag and value from edge N until edge N+1.
REQ-017 ALU arithmetic is modulo 2^GPR_SIZE; shift ops (LSL, LSR, ASR) shift val_a by val_b[5:0]; MOV gives val_b.
REQ-018 CSEL gives cond?a:b; CSINC gives cond?a:b+1; CSINV gives cond?a:~b; CSNEG gives cond?a:-b; BCOND gives value 0.
REQ-019 cond is evaluated from in_rs_alu_nzcv using ARM semantics; 14 and 15 are true; out_alu_condition is registered with every accepted ALU op, and is 0 for non-conditional ops.
REQ-020 If set_nzcv=1: ADD/SUB give N=msb, Z=(result==0), C=carry-out (SUB: no borrow), V=signed overflow; logical/shift/MOV ops give N and Z from the result with C=V=0; out_rob_set_nzcv=1.
REQ-021 If set_nzcv=0, out_rob_nzcv echoes in_rs_alu_nzcv and out_rob_set_nzcv=0.
REQ-022 LS is a 2-stage pipeline: stage1 (edge N) latches op, address (val_a+val_b), tag and store data; stage2 (edge N+1) reads or writes memory and drives the result.
REQ-023 Memory index is addr[10:3] modulo DMEM_WORDS; low 3 address bits are ignored.
REQ-024 LDUR value is mem[index]. STUR performs mem[index] <= in_rs_ls_val_b with store data latched at issue, takes address val_a+0, and returns value 0.
REQ-025 LS results always drive out_rob_set_nzcv=0 and out_rob_nzcv=0.
REQ-026 out_rs_ls_ready = !(stage1 valid). out_rs_alu_ready = !(stage1 valid), which guarantees no result-bus collision.
REQ-027 With no result due, out_rob_done=0 and other bus outputs hold their last values.
REQ-028 Simultaneous ALU and LS starts while both ready are both accepted; the ALU result is emitted at N+1 and the LS result at N+2.
REQ-029 Back-to-back ALU starts complete one per cycle.

Reset
REQ-030 While in_rst=0: all bus outputs, out_alu_condition, both ready outputs and the stage1 valid bit are 0, and all DMEM_WORDS memory words are 0.
REQ-031 Reset asserted mid-operation discards in-flight ops; no done pulse follows.
REQ-032 Ready outputs are 1 in the first cycle after reset deasserts.

Verification
REQ-033 ADD a=5, b=7, set_nzcv=1, tag 3 -> next cycle done=1, tag 3, value 12, nzcv=0000, set_nzcv=1.
REQ-034 SUB a=3, b=3, set_nzcv=1 -> value 0, nzcv=0110; SUB a=0, b=1 -> value 0xFFFF_FFFF_FFFF_FFFF, nzcv=1000.
REQ-035 CSEL a=1, b=2, cond EQ, in nzcv=0100 -> value 1, out_alu_condition=1; repeat with nzcv=0000 -> value 2, condition 0.
REQ-036 STUR a=0x40, b=0xABCD, then LDUR a=0x38, b=8, tag 5 -> load done two cycles after its issue, value 0xABCD, tag 5.
REQ-037 Simultaneous ALU and LS starts -> ALU done at N+1 and LS done at N+2; both ready signals are 0 during cycle N+1.
REQ-038 in_rst pulsed low between an LDUR issue and its completion -> no done pulse; outputs 0; ready signals 1 after release.
